commit_tracker: RTL and testbench

//  Parametrised difftest commit front-end for the superscalar/pipelined core. Accepts up to

---
 rtl/commit_tracker_pkg.sv | 25 ++
 rtl/commit_tracker_fifo.sv | 133 +++++++++++++
 rtl/commit_tracker.sv | 133 +++++++++++++
 tb/tb_commit_tracker.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/commit_tracker_pkg.sv
// rtl/commit_tracker_pkg.sv - shared types, defaults and helpers for the difftest commit front-end
package commit_tracker_pkg;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  localparam int unsigned DEF_COMMIT_WIDTH = 2;
  localparam int unsigned DEF_DEPTH        = 8;
  localparam int unsigned DEF_XLEN         = 64;
  localparam logic [63:0] DEF_PC_START     = 64'h8000_0000;
  localparam logic [6:0]  DEF_TRAP_OPCODE  = 7'h6b;

  // Number of set bits of v strictly below bit position 'lane' (lane compaction offset).
  function automatic int unsigned popcount_below(input logic [3:0] v, input int unsigned lane);
    int unsigned n;
    n = 0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (k < lane && v[k]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/commit_tracker_fifo.sv
// rtl/commit_tracker_fifo.sv - multi-write single-read commit queue with lane compaction and flush
module commit_tracker_fifo
  import commit_tracker_pkg::*;
#(
  parameter  int unsigned W     = DEF_COMMIT_WIDTH,
  parameter  int unsigned DEPTH = DEF_DEPTH,
  parameter  int unsigned XLEN  = DEF_XLEN,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned PW    = AW + 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push_en,
  input  logic [W-1:0]      in_valid,
  input  logic [W*XLEN-1:0] in_pc,
  input  logic [W*32-1:0]   in_inst,
  input  logic [W-1:0]      in_wen,
  input  logic [W*5-1:0]    in_wdest,
  input  logic [W*XLEN-1:0] in_wdata,
  input  logic              pop,
  input  logic              flush,
  output logic [PW-1:0]     count,
  output logic              head_valid,
  output logic [XLEN-1:0]   head_pc,
  output logic [31:0]       head_inst,
  output logic              head_wen,
  output logic [4:0]        head_wdest,
  output logic [XLEN-1:0]   head_wdata
);

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [31:0]     inst_mem  [DEPTH];
  logic [DEPTH-1:0] wen_mem;
  logic [4:0]      wdest_mem [DEPTH];
  logic [XLEN-1:0] wdata_mem [DEPTH];

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   lane_ptr [W];
  logic [PW-1:0]   n_in;
  logic [3:0]      valid_pad;

  logic            head_valid_q, head_valid_d;
  logic [XLEN-1:0] head_pc_q, head_pc_d;
  logic [31:0]     head_inst_q, head_inst_d;
  logic            head_wen_q, head_wen_d;
  logic [4:0]      head_wdest_q, head_wdest_d;
  logic [XLEN-1:0] head_wdata_q, head_wdata_d;

  assign valid_pad = 4'(in_valid);
  assign count     = wr_ptr_q - rd_ptr_q;

  always_comb begin
    n_in = PW'(popcount_below(valid_pad, W));
    for (int unsigned i = 0; i < W; i++) begin
      lane_ptr[i] = wr_ptr_q + PW'(popcount_below(valid_pad, i));
    end

    wr_ptr_d = wr_ptr_q + (push_en ? n_in : '0);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    if (flush) begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = wr_ptr_q;
    end

    head_valid_d = (wr_ptr_d != rd_ptr_d);
    head_pc_d    = head_pc_q;
    head_inst_d  = head_inst_q;
    head_wen_d   = head_wen_q;
    head_wdest_d = head_wdest_q;
    head_wdata_d = head_wdata_q;
    // The next head may be an entry being written this very edge; bypass it from the lanes.
    if (head_valid_d) begin
      head_pc_d    = pc_mem[rd_ptr_d[AW-1:0]];
      head_inst_d  = inst_mem[rd_ptr_d[AW-1:0]];
      head_wen_d   = wen_mem[rd_ptr_d[AW-1:0]];
      head_wdest_d = wdest_mem[rd_ptr_d[AW-1:0]];
      head_wdata_d = wdata_mem[rd_ptr_d[AW-1:0]];
      for (int unsigned i = 0; i < W; i++) begin
        if (push_en && in_valid[i] && lane_ptr[i] == rd_ptr_d) begin
          head_pc_d    = in_pc[i*XLEN +: XLEN];
          head_inst_d  = in_inst[i*32 +: 32];
          head_wen_d   = in_wen[i];
          head_wdest_d = in_wdest[i*5 +: 5];
          head_wdata_d = in_wdata[i*XLEN +: XLEN];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      head_valid_q <= 1'b0;
      head_pc_q    <= '0;
      head_inst_q  <= '0;
      head_wen_q   <= 1'b0;
      head_wdest_q <= '0;
      head_wdata_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      head_valid_q <= head_valid_d;
      head_pc_q    <= head_pc_d;
      head_inst_q  <= head_inst_d;
      head_wen_q   <= head_wen_d;
      head_wdest_q <= head_wdest_d;
      head_wdata_q <= head_wdata_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_en) begin
      for (int unsigned i = 0; i < W; i++) begin
        if (in_valid[i]) begin
          pc_mem[lane_ptr[i][AW-1:0]]    <= in_pc[i*XLEN +: XLEN];
          inst_mem[lane_ptr[i][AW-1:0]]  <= in_inst[i*32 +: 32];
          wen_mem[lane_ptr[i][AW-1:0]]   <= in_wen[i];
          wdest_mem[lane_ptr[i][AW-1:0]] <= in_wdest[i*5 +: 5];
          wdata_mem[lane_ptr[i][AW-1:0]] <= in_wdata[i*XLEN +: XLEN];
        end
      end
    end
  end

  assign head_valid = head_valid_q;
  assign head_pc    = head_pc_q;
  assign head_inst  = head_inst_q;
  assign head_wen   = head_wen_q;
  assign head_wdest = head_wdest_q;
  assign head_wdata = head_wdata_q;

endmodule

// File: rtl/commit_tracker.sv
// rtl/commit_tracker.sv - difftest commit front-end: queue, skip flag, counters and halt-on-trap
module commit_tracker
  import commit_tracker_pkg::*;
#(
  parameter int unsigned     COMMIT_WIDTH = DEF_COMMIT_WIDTH,
  parameter int unsigned     DEPTH        = DEF_DEPTH,
  parameter int unsigned     XLEN         = DEF_XLEN,
  parameter logic [XLEN-1:0] PC_START     = DEF_PC_START[XLEN-1:0],
  parameter logic [6:0]      TRAP_OPCODE  = DEF_TRAP_OPCODE
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [COMMIT_WIDTH-1:0]      in_valid,
  input  logic [COMMIT_WIDTH*XLEN-1:0] in_pc,
  input  logic [COMMIT_WIDTH*32-1:0]   in_inst,
  input  logic [COMMIT_WIDTH-1:0]      in_wen,
  input  logic [COMMIT_WIDTH*5-1:0]    in_wdest,
  input  logic [COMMIT_WIDTH*XLEN-1:0] in_wdata,
  output logic                         in_ready,
  input  logic [XLEN-1:0]              a0_value,
  input  logic                         cmt_ready,
  output logic                         cmt_valid,
  output logic [XLEN-1:0]              cmt_pc,
  output logic [31:0]                  cmt_inst,
  output logic                         cmt_wen,
  output logic [7:0]                   cmt_wdest,
  output logic [XLEN-1:0]              cmt_wdata,
  output logic                         cmt_skip,
  output logic                         trap_valid,
  output logic [7:0]                   trap_code,
  output logic [XLEN-1:0]              trap_pc,
  output logic [63:0]                  cycle_cnt,
  output logic [63:0]                  instr_cnt,
  output logic                         halted
);

  localparam int unsigned PW = $clog2(DEPTH) + 1;

  state_e          state_q, state_d;
  logic            first_done_q, first_done_d;
  logic [63:0]     cycle_cnt_q, cycle_cnt_d;
  logic [63:0]     instr_cnt_q, instr_cnt_d;
  logic            trap_valid_q, trap_valid_d;
  logic [7:0]      trap_code_q, trap_code_d;
  logic [XLEN-1:0] trap_pc_q, trap_pc_d;

  logic [PW-1:0]   count;
  logic [4:0]      head_wdest;
  logic            pop, is_trap;
  logic            unused_a0_hi;

  assign in_ready     = (state_q == ST_RUN) && (count <= PW'(DEPTH - COMMIT_WIDTH));
  assign pop          = cmt_valid && cmt_ready;
  assign is_trap      = pop && (cmt_inst[6:0] == TRAP_OPCODE);
  assign unused_a0_hi = ^a0_value[XLEN-1:8];

  // A trap pop flushes the queue, which also discards any group enqueued on that edge.
  commit_tracker_fifo #(
    .W     (COMMIT_WIDTH),
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .push_en    (in_ready),
    .in_valid   (in_valid),
    .in_pc      (in_pc),
    .in_inst    (in_inst),
    .in_wen     (in_wen),
    .in_wdest   (in_wdest),
    .in_wdata   (in_wdata),
    .pop        (pop),
    .flush      (is_trap),
    .count      (count),
    .head_valid (cmt_valid),
    .head_pc    (cmt_pc),
    .head_inst  (cmt_inst),
    .head_wen   (cmt_wen),
    .head_wdest (head_wdest),
    .head_wdata (cmt_wdata)
  );

  always_comb begin
    state_d      = state_q;
    first_done_d = first_done_q;
    cycle_cnt_d  = cycle_cnt_q;
    instr_cnt_d  = instr_cnt_q;
    trap_valid_d = 1'b0;
    trap_code_d  = trap_code_q;
    trap_pc_d    = trap_pc_q;
    if (state_q == ST_RUN) cycle_cnt_d = cycle_cnt_q + 64'd1;
    if (pop) begin
      first_done_d = 1'b1;
      instr_cnt_d  = instr_cnt_q + 64'd1;
    end
    if (is_trap) begin
      state_d      = ST_HALTED;
      trap_valid_d = 1'b1;
      trap_code_d  = a0_value[7:0];
      trap_pc_d    = cmt_pc;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_RUN;
      first_done_q <= 1'b0;
      cycle_cnt_q  <= '0;
      instr_cnt_q  <= '0;
      trap_valid_q <= 1'b0;
      trap_code_q  <= '0;
      trap_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      first_done_q <= first_done_d;
      cycle_cnt_q  <= cycle_cnt_d;
      instr_cnt_q  <= instr_cnt_d;
      trap_valid_q <= trap_valid_d;
      trap_code_q  <= trap_code_d;
      trap_pc_q    <= trap_pc_d;
    end
  end

  assign cmt_wdest  = {3'b000, head_wdest};
  assign cmt_skip   = cmt_valid && !first_done_q && (cmt_pc == PC_START);
  assign trap_valid = trap_valid_q;
  assign trap_code  = trap_code_q;
  assign trap_pc    = trap_pc_q;
  assign cycle_cnt  = cycle_cnt_q;
  assign instr_cnt  = instr_cnt_q;
  assign halted     = (state_q == ST_HALTED);

endmodule

// File: tb/tb_commit_tracker.sv
// tb/tb_commit_tracker.sv - scoreboard bench for commit_tracker (W=2, DEPTH=8, XLEN=64)
module tb_commit_tracker;

  localparam int W = 2;
  localparam int D = 8;
  localparam logic [63:0] PC0 = 64'h8000_0000;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [W-1:0]  in_valid;
  logic [W*64-1:0] in_pc, in_wdata;
  logic [W*32-1:0] in_inst;
  logic [W-1:0]  in_wen;
  logic [W*5-1:0] in_wdest;
  logic          in_ready;
  logic [63:0]   a0_value;
  logic          cmt_ready;
  logic          cmt_valid, cmt_wen, cmt_skip, trap_valid, halted;
  logic [63:0]   cmt_pc, cmt_wdata, trap_pc, cycle_cnt, instr_cnt;
  logic [31:0]   cmt_inst;
  logic [7:0]    cmt_wdest, trap_code;

  always #5 clock = ~clock;

  commit_tracker dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_wen(in_wen),
    .in_wdest(in_wdest), .in_wdata(in_wdata), .in_ready(in_ready),
    .a0_value(a0_value), .cmt_ready(cmt_ready),
    .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .cmt_inst(cmt_inst), .cmt_wen(cmt_wen),
    .cmt_wdest(cmt_wdest), .cmt_wdata(cmt_wdata), .cmt_skip(cmt_skip),
    .trap_valid(trap_valid), .trap_code(trap_code), .trap_pc(trap_pc),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt), .halted(halted)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        wen;
    logic [4:0]  rd;
    logic [63:0] data;
  } ent_t;

  ent_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  bit m_halted, m_first_done, m_trap_pulse;
  logic [63:0] m_cycle, m_instr, m_trap_pc;
  logic [7:0]  m_trap_code;

  function automatic logic [31:0] addi_for(input logic [63:0] pc);
    return {20'h00000, pc[6:2], 7'h13};
  endfunction

  task automatic reset_model();
    sb.delete();
    m_halted = 0; m_first_done = 0; m_trap_pulse = 0;
    m_cycle = '0; m_instr = '0; m_trap_pc = '0; m_trap_code = '0;
  endtask

  task automatic clear_lanes();
    in_valid = '0; in_pc = '0; in_inst = '0; in_wen = '0; in_wdest = '0; in_wdata = '0;
  endtask

  task automatic set_lane(input int i, input logic [63:0] pc, input logic [31:0] inst);
    in_valid[i]         = 1'b1;
    in_pc[i*64 +: 64]   = pc;
    in_inst[i*32 +: 32] = inst;
    in_wen[i]           = pc[2];
    in_wdest[i*5 +: 5]  = pc[6:2];
    in_wdata[i*64 +: 64] = {pc[31:0], ~inst};
  endtask

  // One clock: compare DUT outputs to the model, advance the model, then cross one edge.
  task automatic step();
    ent_t e;
    bit exp_ready, exp_valid, exp_skip, trap_now;
    exp_ready = !m_halted && (sb.size() <= D - W);
    exp_valid = !m_halted && (sb.size() != 0);
    vectors++;
    if (in_ready !== exp_ready) begin miscompares++; $display("FAIL in_ready: got %b want %b", in_ready, exp_ready); end
    vectors++;
    if (cmt_valid !== exp_valid) begin miscompares++; $display("FAIL cmt_valid: got %b want %b", cmt_valid, exp_valid); end
    vectors++;
    if ({trap_valid, halted, trap_code, trap_pc} !== {m_trap_pulse, m_halted, m_trap_code, m_trap_pc}) begin
      miscompares++;
      $display("FAIL trap_state: got v=%b h=%b code=%h pc=%h want v=%b h=%b code=%h pc=%h",
               trap_valid, halted, trap_code, trap_pc, m_trap_pulse, m_halted, m_trap_code, m_trap_pc);
    end
    vectors++;
    if ({cycle_cnt, instr_cnt} !== {m_cycle, m_instr}) begin
      miscompares++;
      $display("FAIL counters: got cyc=%0d ins=%0d want cyc=%0d ins=%0d", cycle_cnt, instr_cnt, m_cycle, m_instr);
    end
    trap_now = 0;
    m_trap_pulse = 0;
    if (exp_valid) begin
      e = sb[0];
      exp_skip = !m_first_done && (e.pc == PC0);
      vectors++;
      if ({cmt_pc, cmt_inst, cmt_wen, cmt_wdest, cmt_wdata, cmt_skip} !== {e.pc, e.inst, e.wen, 3'b000, e.rd, e.data, exp_skip}) begin
        miscompares++;
        $display("FAIL head_entry: got pc=%h inst=%h wen=%b rd=%h data=%h skip=%b want pc=%h inst=%h wen=%b rd=%h data=%h skip=%b",
                 cmt_pc, cmt_inst, cmt_wen, cmt_wdest, cmt_wdata, cmt_skip, e.pc, e.inst, e.wen, e.rd, e.data, exp_skip);
      end
      if (cmt_ready) begin
        void'(sb.pop_front());
        m_instr = m_instr + 64'd1;
        m_first_done = 1;
        if (e.inst[6:0] == 7'h6b) begin
          trap_now = 1;
          m_trap_pulse = 1;
          m_trap_code = a0_value[7:0];
          m_trap_pc = e.pc;
        end
      end
    end
    if (!m_halted) m_cycle = m_cycle + 64'd1;
    if (exp_ready) begin
      for (int i = 0; i < W; i++) begin
        if (in_valid[i]) begin
          e.pc = in_pc[i*64 +: 64]; e.inst = in_inst[i*32 +: 32]; e.wen = in_wen[i];
          e.rd = in_wdest[i*5 +: 5]; e.data = in_wdata[i*64 +: 64];
          sb.push_back(e);
        end
      end
    end
    if (trap_now) begin
      m_halted = 1;
      sb.delete();
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drain(input string tag);
    cmt_ready = 1'b1;
    clear_lanes();
    for (int k = 0; k < 20 && sb.size() != 0; k++) step();
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("FAIL %s_drain: got %0d left want 0", tag, sb.size()); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({cmt_valid, cmt_pc, cmt_inst, cmt_wen, cmt_wdest, cmt_wdata, cmt_skip, trap_valid, trap_code, trap_pc, cycle_cnt, instr_cnt, halted} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got pc=%h inst=%h cyc=%0d ins=%0d v=%b h=%b want all 0", cmt_pc, cmt_inst, cycle_cnt, instr_cnt, cmt_valid, halted);
    end
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    reset_model();
    step();
  endtask

  task automatic test_skip();
    cmt_ready = 1'b1;
    set_lane(0, PC0, addi_for(PC0));
    step();
    clear_lanes();
    vectors++;
    if ({cmt_valid, cmt_skip, cmt_pc} !== {1'b1, 1'b1, PC0}) begin
      miscompares++; $display("FAIL skip_first: got v=%b skip=%b pc=%h want v=1 skip=1 pc=%h", cmt_valid, cmt_skip, cmt_pc, PC0);
    end
    step();
    vectors++;
    if ({instr_cnt, cmt_skip} !== {64'd1, 1'b0}) begin
      miscompares++; $display("FAIL skip_count: got ins=%0d skip=%b want ins=1 skip=0", instr_cnt, cmt_skip);
    end
  endtask

  task automatic test_compaction();
    cmt_ready = 1'b0;
    set_lane(1, PC0 + 64'h4, addi_for(PC0 + 64'h4));
    step();
    clear_lanes();
    vectors++;
    if ({cmt_valid, cmt_pc} !== {1'b1, PC0 + 64'h4}) begin
      miscompares++; $display("FAIL compact_lane1: got v=%b pc=%h want v=1 pc=%h", cmt_valid, cmt_pc, PC0 + 64'h4);
    end
    set_lane(0, PC0 + 64'h8, addi_for(PC0 + 64'h8));
    set_lane(1, PC0 + 64'hc, addi_for(PC0 + 64'hc));
    cmt_ready = 1'b1;
    step();
    clear_lanes();
    vectors++;
    if (cmt_pc !== PC0 + 64'h8) begin miscompares++; $display("FAIL compact_order0: got %h want %h", cmt_pc, PC0 + 64'h8); end
    step();
    vectors++;
    if (cmt_pc !== PC0 + 64'hc) begin miscompares++; $display("FAIL compact_order1: got %h want %h", cmt_pc, PC0 + 64'hc); end
    drain("compact");
  endtask

  task automatic test_full();
    cmt_ready = 1'b0;
    for (int g = 0; g < 4; g++) begin
      set_lane(0, PC0 + 64'h100 + 64'(g * 8), addi_for(PC0 + 64'h100 + 64'(g * 8)));
      set_lane(1, PC0 + 64'h104 + 64'(g * 8), 32'h0000_0033);
      step();
    end
    clear_lanes();
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready: got %b want 0", in_ready); end
    cmt_ready = 1'b1; step(); cmt_ready = 1'b0;
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL full_pop1_ready: got %b want 0", in_ready); end
    cmt_ready = 1'b1; step(); cmt_ready = 1'b0;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL full_pop2_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    // six entries left by test_full: push two while popping one, then try a push while not ready
    cmt_ready = 1'b1;
    set_lane(0, PC0 + 64'h200, addi_for(PC0 + 64'h200));
    set_lane(1, PC0 + 64'h204, addi_for(PC0 + 64'h204));
    step();
    vectors++;
    if ({in_ready, 32'(sb.size())} !== {1'b0, 32'd7}) begin
      miscompares++; $display("FAIL b2b_count7: got ready=%b sb=%0d want ready=0 sb=7", in_ready, sb.size());
    end
    set_lane(0, PC0 + 64'h300, addi_for(PC0 + 64'h300));
    set_lane(1, PC0 + 64'h304, addi_for(PC0 + 64'h304));
    step();
    drain("b2b");
  endtask

  task automatic test_trap();
    a0_value = 64'h1234_5600;
    cmt_ready = 1'b0;
    set_lane(0, PC0 + 64'h10, 32'h0000_006b);
    set_lane(1, PC0 + 64'h14, addi_for(PC0 + 64'h14));
    step();
    set_lane(0, PC0 + 64'h18, addi_for(PC0 + 64'h18));
    set_lane(1, PC0 + 64'h1c, addi_for(PC0 + 64'h1c));
    step();
    cmt_ready = 1'b1;
    set_lane(0, PC0 + 64'h20, addi_for(PC0 + 64'h20));
    set_lane(1, PC0 + 64'h24, addi_for(PC0 + 64'h24));
    step();
    clear_lanes();
    vectors++;
    if ({trap_valid, halted, trap_code, trap_pc, cmt_valid, in_ready} !== {1'b1, 1'b1, 8'h00, PC0 + 64'h10, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL trap_pulse: got v=%b h=%b code=%h pc=%h cv=%b rdy=%b want v=1 h=1 code=00 pc=%h cv=0 rdy=0",
               trap_valid, halted, trap_code, trap_pc, cmt_valid, in_ready, PC0 + 64'h10);
    end
    set_lane(0, PC0 + 64'h28, addi_for(PC0 + 64'h28));
    step();
    step();
    clear_lanes();
    vectors++;
    if ({trap_valid, cycle_cnt, cmt_valid} !== {1'b0, m_cycle, 1'b0}) begin
      miscompares++; $display("FAIL trap_frozen: got v=%b cyc=%0d cv=%b want v=0 cyc=%0d cv=0", trap_valid, cycle_cnt, cmt_valid, m_cycle);
    end
  endtask

  task automatic test_midreset();
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    reset_model();
    cmt_ready = 1'b0;
    for (int g = 0; g < 3; g++) begin
      set_lane(0, PC0 + 64'h400 + 64'(g * 8), addi_for(PC0 + 64'h400 + 64'(g * 8)));
      if (g < 2) set_lane(1, PC0 + 64'h404 + 64'(g * 8), addi_for(PC0 + 64'h404 + 64'(g * 8)));
      step();
      clear_lanes();
    end
    vectors++;
    if (sb.size() != 5 || cmt_valid !== 1'b1) begin
      miscompares++; $display("FAIL midreset_fill: got sb=%0d v=%b want sb=5 v=1", sb.size(), cmt_valid);
    end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if ({cmt_valid, cmt_pc, cmt_inst, cmt_wdata, cycle_cnt, instr_cnt, halted, trap_valid, in_ready} !== {64'd0, 64'd0, 64'd0, 32'd0, 64'd0, 3'b000, 1'b1}) begin
      miscompares++;
      $display("FAIL midreset_async: got v=%b pc=%h cyc=%0d ins=%0d rdy=%b want v=0 pc=0 cyc=0 ins=0 rdy=1",
               cmt_valid, cmt_pc, cycle_cnt, instr_cnt, in_ready);
    end
    @(negedge clock);
    reset_n = 1'b1;
    reset_model();
    cmt_ready = 1'b1;
    repeat (3) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    clear_lanes();
    a0_value = '0;
    cmt_ready = 1'b0;
    reset_model();
    test_reset();
    test_skip();
    test_compaction();
    test_full();
    test_back_to_back();
    test_trap();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
